id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the decode control unit.
- Captures control bits (brnch, mem_rd, mem_to_rgs, alu_op, mem_wr, alu_src, reg_wr), operands, immediate, PC and register indices, and presents them to the execute stage one cycle later.
- Contains load-use hazard detection: requests an upstream stall and inserts a bubble.
- Honours branch flush and global memory stall, and counts inserted bubbles.

Parameters:
XLEN, 32, datapath width of PC, operands, immediate
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  PC of decoded instruction
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
id_funct  in  4  {funct7[5], funct3} for ALU control
id_brnch, id_mem_rd, id_mem_to_rgs, id_mem_wr, id_alu_src, id_reg_wr  in  1 each  control bits from decode
id_alu_op  in  3  ALU op class from decode
flush  in  1  branch taken in later stage; squash decode slot
ext_stall  in  1  memory/backend stall; freeze pipeline
hazard_stall  out  1  load-use hazard; IF/ID must hold
ex_valid  out  1  EX slot holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
ex_funct  out  4  registered funct
ex_brnch, ex_mem_rd, ex_mem_to_rgs, ex_mem_wr, ex_alu_src, ex_reg_wr  out  1 each  registered control
ex_alu_op  out  3  registered ALU op
bubble_cnt  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Reset (reset=0, async): all ex_* outputs 0, ex_alu_op=000, ex_valid=0, bubble_cnt=0. hazard_stall therefore 0. Registers update on the first rising clk after reset=1.
- Latency: 1 cycle, ID inputs at edge N appear on ex_* after edge N.
- rs2_used = ~id_alu_src | id_mem_wr. rs2 is ignored for I-type ALU and loads.
- hazard_raw = id_valid & ex_valid & ex_mem_rd & (ex_rd != 0) & ((ex_rd == id_rs1) | (rs2_used & ex_rd == id_rs2)).
- hazard_stall = hazard_raw & ~flush & ~ext_stall. Purely combinational from registered EX state and ID inputs.
- Per-edge update, in priority order:
  1. ext_stall=1: all ex_* registers and bubble_cnt hold. flush and hazard are ignored that cycle. The flush source holds flush until ext_stall drops.
  2. flush=1: bubble. ex_valid=0, all ex control bits and ex_alu_op=0; data/index fields hold previous values. bubble_cnt increments.
  3. hazard_raw=1: bubble, same as flush. bubble_cnt increments. Upstream holds the instruction, so it is re-presented next cycle and its hazard clears.
  4. Otherwise: capture all id_* fields. ex_valid=id_valid.
- Capture with id_valid=0: control bits are still forced to 0 regardless of inputs. Decode may emit default-case control.
- Decode's default (unknown opcode) all-zero control passes through unchanged with ex_valid=id_valid. It behaves as a NOP.
- bubble_cnt saturates at 2^CNT_W-1. It never wraps.
- Reset mid-stall or mid-flush: immediate clear. No pending state survives reset.
- No forwarding in this block. rs1/rs2 indices are registered for a downstream forwarding unit.

Test Plan:
- Reset asserted mid-run with ex_reg_wr=1, ex_valid=1 -> same cycle ex_* all 0, bubble_cnt=0, hazard_stall=0.
- R-type add, id_rs1=3, id_rs2=4, id_rd=5, id_alu_op=010, id_rs1_data=0x10 -> next cycle ex_valid=1, ex_reg_wr=1, ex_alu_op=010, ex_rs1_data=0x10, ex_rd=5.
- Load to x5 (ex_mem_rd=1, ex_rd=5), then add using rs1=5 -> hazard_stall=1 for one cycle; next cycle ex_valid=0, controls 0, bubble_cnt=1; add captured the following cycle.
- Load to x0, then instruction reading x0 -> hazard_stall=0, no bubble. Load to x5, then addi with rs2=5 (alu_src=1, mem_wr=0) -> no stall.
- flush=1 with hazard_raw=1 -> hazard_stall=0, bubble inserted, bubble_cnt +1 only once.
- ext_stall=1 for 3 cycles with flush=1 -> ex_* unchanged, bubble_cnt unchanged. After release with flush still 1, one bubble. With CNT_W=2, 5 bubbles -> bubble_cnt=3.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush/stall handling and bubble counting
// Ports:
//   clk, reset (async, active-low)
//   id_*         decoded instruction fields and control bits from the decode stage
//   flush        squash the decode slot (branch taken downstream)
//   ext_stall    freeze the whole stage
//   hazard_stall load-use hazard, IF/ID must hold its instruction
//   ex_*         registered copies presented to the execute stage
//   bubble_cnt   saturating count of inserted bubbles
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             id_brnch,
  input  logic             id_mem_rd,
  input  logic             id_mem_to_rgs,
  input  logic             id_mem_wr,
  input  logic             id_alu_src,
  input  logic             id_reg_wr,
  input  logic [2:0]       id_alu_op,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic             ex_brnch,
  output logic             ex_mem_rd,
  output logic             ex_mem_to_rgs,
  output logic             ex_mem_wr,
  output logic             ex_alu_src,
  output logic             ex_reg_wr,
  output logic [2:0]       ex_alu_op,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic [8:0] id_ctrl, ex_ctrl;
  logic       rs2_used, hazard_raw;
  assign id_ctrl = {id_brnch, id_mem_rd, id_mem_to_rgs, id_mem_wr, id_alu_src, id_reg_wr, id_alu_op};
  assign {ex_brnch, ex_mem_rd, ex_mem_to_rgs, ex_mem_wr, ex_alu_src, ex_reg_wr, ex_alu_op} = ex_ctrl;
  // I-type ALU ops and loads take the immediate, so their rs2 field is not a real read
  assign rs2_used     = ~id_alu_src | id_mem_wr;
  assign hazard_raw   = id_valid & ex_valid & ex_mem_rd & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (rs2_used & (ex_rd == id_rs2)));
  assign hazard_stall = hazard_raw & ~flush & ~ext_stall;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      bubble_cnt  <= '0;
    end else if (!ext_stall) begin
      if (flush | hazard_raw) begin
        // bubble: only valid/control are cleared, data fields keep their old values
        ex_valid   <= 1'b0;
        ex_ctrl    <= '0;
        bubble_cnt <= bubble_cnt + CNT_W'(bubble_cnt != '1);
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl     <= id_valid ? id_ctrl : '0;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct    <= id_funct;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with directed and random stimulus
module tb_id_ex_stage;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
  typedef struct packed {
    logic v;
    logic [31:0] pc, a, b, imm;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] funct;
    logic brnch, mem_rd, mem_to_rgs, mem_wr, alu_src, reg_wr;
    logic [2:0] alu_op;
  } slot_t;
  typedef struct {
    slot_t s;
    int cnt;
    bit hz;
    bit rst;
  } exp_t;
  logic clk = 0, reset = 0, flush = 0, ext_stall = 0;
  slot_t id = '0, act, m = '0;
  int mcnt = 0, vectors = 0, miscompares = 0;
  bit last_hz = 0;
  exp_t q[$];
  logic hazard_stall, ex_valid, ex_brnch, ex_mem_rd, ex_mem_to_rgs, ex_mem_wr, ex_alu_src, ex_reg_wr;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_funct;
  logic [2:0] ex_alu_op;
  logic [CNT_W-1:0] bubble_cnt;
  id_ex_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id.v), .id_pc(id.pc), .id_rs1_data(id.a), .id_rs2_data(id.b),
    .id_imm(id.imm), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct(id.funct),
    .id_brnch(id.brnch), .id_mem_rd(id.mem_rd), .id_mem_to_rgs(id.mem_to_rgs), .id_mem_wr(id.mem_wr),
    .id_alu_src(id.alu_src), .id_reg_wr(id.reg_wr), .id_alu_op(id.alu_op), .flush(flush),
    .ext_stall(ext_stall), .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_brnch(ex_brnch), .ex_mem_rd(ex_mem_rd),
    .ex_mem_to_rgs(ex_mem_to_rgs), .ex_mem_wr(ex_mem_wr), .ex_alu_src(ex_alu_src),
    .ex_reg_wr(ex_reg_wr), .ex_alu_op(ex_alu_op), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
                ex_brnch, ex_mem_rd, ex_mem_to_rgs, ex_mem_wr, ex_alu_src, ex_reg_wr, ex_alu_op};
  function automatic slot_t no_ctl(slot_t x);
    slot_t y = x;
    y.brnch = 0; y.mem_rd = 0; y.mem_to_rgs = 0; y.mem_wr = 0; y.alu_src = 0; y.reg_wr = 0; y.alu_op = 0;
    return y;
  endfunction
  function automatic slot_t rnd_slot();
    slot_t s;
    s.v = $urandom_range(0, 3) != 0;
    s.pc = $urandom; s.a = $urandom; s.b = $urandom; s.imm = $urandom;
    s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7)); s.rd = 5'($urandom_range(0, 7));
    s.funct = 4'($urandom);
    s.brnch = 1'($urandom); s.mem_rd = $urandom_range(0, 2) == 0; s.mem_to_rgs = 1'($urandom);
    s.mem_wr = 1'($urandom); s.alu_src = 1'($urandom); s.reg_wr = 1'($urandom); s.alu_op = 3'($urandom);
    return s;
  endfunction
  // kind: 0 R-type ALU, 1 load, 2 I-type ALU, 3 store
  function automatic slot_t ins(int kind, int rs1, int rs2, int rd);
    slot_t s = no_ctl(rnd_slot());
    s.v = 1; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.mem_rd = kind == 1; s.mem_to_rgs = kind == 1; s.mem_wr = kind == 3;
    s.alu_src = kind != 0; s.reg_wr = kind != 3; s.alu_op = (kind == 0 || kind == 2) ? 3'b010 : 3'b000;
    return s;
  endfunction
  task automatic apply(slot_t i, bit fl, bit es);
    exp_t e;
    bit raw;
    @(negedge clk);
    reset = 1; id = i; flush = fl; ext_stall = es;
    raw = i.v && m.v && m.mem_rd && m.rd != 0 && (m.rd == i.rs1 || ((!i.alu_src || i.mem_wr) && m.rd == i.rs2));
    e.hz = raw && !fl && !es;
    if (!es) begin
      if (fl || raw) begin
        m = no_ctl(m); m.v = 0;
        if (mcnt < MAXC) mcnt++;
      end else m = i.v ? i : no_ctl(i);
    end
    e.s = m; e.cnt = mcnt; e.rst = 0;
    q.push_back(e);
    last_hz = e.hz;
  endtask
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    reset = 0;
    m = '0; mcnt = 0; last_hz = 0;
    e.s = m; e.cnt = 0; e.hz = 0; e.rst = 1;
    q.push_back(e);
  endtask
  task automatic chk_state(string tag, exp_t e);
    vectors++;
    if (act !== e.s || bubble_cnt !== CNT_W'(e.cnt)) begin
      miscompares++;
      $display("FAIL %s t=%0t ex=%h cnt=%0d expected ex=%h cnt=%0d", tag, $time, act, bubble_cnt, e.s, e.cnt);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (hazard_stall !== e.hz) begin
          miscompares++;
          $display("FAIL hazard_stall t=%0t got %b expected %b", $time, hazard_stall, e.hz);
        end
        if (e.rst) chk_state("async_reset", e);
        @(posedge clk);
        #1;
        chk_state("ex_regs", e);
      end
    end
  end
  initial begin : driver
    slot_t cur, add;
    bit fl = 0, es = 0;
    do_reset();
    add = ins(0, 3, 4, 5); add.a = 32'h10;
    apply(add, 0, 0);
    apply(ins(1, 1, 0, 5), 0, 0);
    add = ins(0, 5, 6, 7);
    apply(add, 0, 0);
    apply(add, 0, 0);
    apply(ins(1, 2, 0, 0), 0, 0);
    apply(ins(0, 0, 0, 8), 0, 0);
    apply(ins(1, 2, 0, 5), 0, 0);
    apply(ins(2, 1, 5, 9), 0, 0);
    apply(ins(1, 2, 0, 5), 0, 0);
    apply(ins(3, 1, 5, 0), 0, 0);
    apply(ins(1, 2, 0, 5), 0, 0);
    apply(ins(0, 5, 1, 3), 1, 0);
    apply(no_ctl(ins(0, 1, 2, 3)), 0, 0);
    cur = rnd_slot(); cur.v = 0;
    apply(cur, 0, 0);
    apply(ins(1, 2, 0, 6), 0, 0);
    repeat (3) apply(ins(0, 6, 1, 2), 1, 1);
    apply(ins(0, 6, 1, 2), 1, 0);
    repeat (5) apply(rnd_slot(), 1, 0);
    apply(ins(0, 1, 2, 3), 0, 0);
    do_reset();
    apply(ins(0, 1, 2, 3), 0, 0);
    cur = rnd_slot();
    for (int n = 0; n < 1500; n++) begin
      if (!last_hz) cur = rnd_slot();
      fl = (es && fl) ? 1'b1 : ($urandom_range(0, 9) == 0);
      es = $urandom_range(0, 6) == 0;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        es = 0;
      end else apply(cur, fl, es);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
